// File: rtl/oflow_core_reg_pkg.sv
// Shared types and defaults for the registration result write-back path.
package oflow_core_reg_pkg;

    localparam int PE_NUM_DEF = 24;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int MASK_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

    // Thermometer mask with the lowest cnt bits set; callers keep the low PE_NUM bits.
    function automatic logic [MASK_MAX-1:0] active_mask_f(input int unsigned cnt);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 32'd0; i < 32'(MASK_MAX); i++) begin
            if (i < cnt) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/oflow_rr_picker.sv
// Combinational round-robin picker: first set bit of eligible at or after rr_ptr, wrapping at N.
module oflow_rr_picker #(
    parameter int N     = 24,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    function automatic logic [IDX_W-1:0] wrap_pos(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(N)) begin
            s = s - 32'(N);
        end else begin
            s = s;
        end
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[wrap_pos(rr_ptr, 32'(k))]) begin
                found = 1'b1;
                idx   = wrap_pos(rr_ptr, 32'(k));
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/oflow_core_reg_wb_arbiter.sv
// Round-robin write-back arbiter for the registration result memory port.
// Optional error monitor (sticky err_o) enabled by OFLOW_WB_ERR_CHECK_EN.
module oflow_core_reg_wb_arbiter
    import oflow_core_reg_pkg::*;
#(
    parameter int PE_NUM   = PE_NUM_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PE_IDX_W = $clog2(PE_NUM),
    parameter int CNT_W    = $clog2(PE_NUM + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_set,
    input  logic [CNT_W-1:0]         num_active_pe,
    input  logic [ADDR_W-1:0]        set_base_addr,
    input  logic [PE_NUM-1:0]        req_i,
    input  logic [PE_NUM*DATA_W-1:0] data_i,
    input  logic                     wr_ready,
`ifdef OFLOW_WB_ERR_CHECK_EN
    output logic                     err_o,
`endif
    output logic [PE_NUM-1:0]        grant_o,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     set_done,
    output logic [CNT_W-1:0]         served_cnt
);

    wb_state_e             state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s, clamped_cnt_s, served_cnt_s;
    logic [ADDR_W-1:0]     base_r, base_s, wr_addr_s;
    logic [PE_NUM-1:0]     served_mask_r, served_mask_s;
    logic [PE_IDX_W-1:0]   rr_ptr_r, rr_ptr_s, pick_idx_s;
    logic [MASK_MAX-1:0]   active_full_s;
    logic [PE_NUM-1:0]     active_mask_s, eligible_s, grant_s;
    logic [DATA_W-1:0]     wr_data_s;
    logic                  pick_found_s, fire_s, last_s;
    logic                  wr_en_s, busy_s, set_done_s;
    logic                  unused_mask_s;

    assign active_full_s = active_mask_f(32'(cnt_r));
    assign active_mask_s = active_full_s[PE_NUM-1:0];
    assign unused_mask_s = ^active_full_s[MASK_MAX-1:PE_NUM];
    assign eligible_s    = req_i & ~served_mask_r & active_mask_s;

    oflow_rr_picker #(
        .N     (PE_NUM),
        .IDX_W (PE_IDX_W)
    ) u_picker (
        .eligible (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Count clamp and grant qualification.
    always_comb begin
        if (32'(num_active_pe) > 32'(PE_NUM)) begin
            clamped_cnt_s = CNT_W'(PE_NUM);
        end else begin
            clamped_cnt_s = num_active_pe;
        end
        if ((state_r == ARB) && pick_found_s && wr_ready) begin
            fire_s = 1'b1;
            last_s = ((served_cnt + CNT_W'(1)) == cnt_r);
        end else begin
            fire_s = 1'b0;
            last_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_set) begin
                    if (clamped_cnt_s == CNT_W'(0)) begin
                        state_s = DONE;
                    end else begin
                        state_s = ARB;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ARB: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ARB;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and per-set bookkeeping.
    always_comb begin
        grant_s       = '0;
        wr_en_s       = 1'b0;
        wr_addr_s     = '0;
        wr_data_s     = '0;
        busy_s        = busy;
        set_done_s    = 1'b0;
        served_cnt_s  = served_cnt;
        served_mask_s = served_mask_r;
        rr_ptr_s      = rr_ptr_r;
        cnt_s         = cnt_r;
        base_s        = base_r;
        case (state_r)
            IDLE: begin
                if (start_set) begin
                    cnt_s         = clamped_cnt_s;
                    base_s        = set_base_addr;
                    served_mask_s = '0;
                    served_cnt_s  = '0;
                    busy_s        = 1'b1;
                end else begin
                    busy_s        = 1'b0;
                end
            end
            ARB: begin
                busy_s = 1'b1;
                if (fire_s) begin
                    grant_s       = {{(PE_NUM-1){1'b0}}, 1'b1} << pick_idx_s;
                    wr_en_s       = 1'b1;
                    wr_addr_s     = base_r + ADDR_W'(pick_idx_s);
                    wr_data_s     = data_i[32'(pick_idx_s) * 32'(DATA_W) +: DATA_W];
                    served_mask_s = served_mask_r | grant_s;
                    served_cnt_s  = served_cnt + CNT_W'(1);
                    if (32'(pick_idx_s) == 32'(PE_NUM - 1)) begin
                        rr_ptr_s = '0;
                    end else begin
                        rr_ptr_s = pick_idx_s + PE_IDX_W'(1);
                    end
                end else begin
                    grant_s = '0;
                end
            end
            DONE: begin
                // busy stays high through the set_done cycle and drops in IDLE.
                busy_s     = 1'b1;
                set_done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_o       <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            set_done      <= 1'b0;
            served_cnt    <= '0;
            served_mask_r <= '0;
            rr_ptr_r      <= '0;
            cnt_r         <= '0;
            base_r        <= '0;
        end else begin
            grant_o       <= grant_s;
            wr_en         <= wr_en_s;
            wr_addr       <= wr_addr_s;
            wr_data       <= wr_data_s;
            busy          <= busy_s;
            set_done      <= set_done_s;
            served_cnt    <= served_cnt_s;
            served_mask_r <= served_mask_s;
            rr_ptr_r      <= rr_ptr_s;
            cnt_r         <= cnt_s;
            base_r        <= base_s;
        end
    end

`ifdef OFLOW_WB_ERR_CHECK_EN
    logic err_s;

    // Sticky protocol error: restart while busy, inactive request, or oversized count.
    always_comb begin
        err_s = err_o;
        if (start_set && (state_r != IDLE)) begin
            err_s = 1'b1;
        end else if ((state_r != IDLE) && (|(req_i & ~active_mask_s))) begin
            err_s = 1'b1;
        end else if (start_set && (32'(num_active_pe) > 32'(PE_NUM))) begin
            err_s = 1'b1;
        end else begin
            err_s = err_o;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_o <= 1'b0;
        end else begin
            err_o <= err_s;
        end
    end
`endif

endmodule

// File: tb/tb_oflow_core_reg_wb_arbiter.sv
// Scoreboard bench for oflow_core_reg_wb_arbiter with a queue-based round-robin reference model.
module tb_oflow_core_reg_wb_arbiter;

    localparam int PE_NUM = 24;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start_set;
    logic [CNT_W-1:0]         num_active_pe;
    logic [ADDR_W-1:0]        set_base_addr;
    logic [PE_NUM-1:0]        req_i;
    logic [PE_NUM*DATA_W-1:0] data_i;
    logic                     wr_ready;
    logic [PE_NUM-1:0]        grant_o;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     busy;
    logic                     set_done;
    logic [CNT_W-1:0]         served_cnt;
`ifdef OFLOW_WB_ERR_CHECK_EN
    logic                     err_o;
`endif

    typedef struct {
        int          idx;
        int          addr;
        logic [31:0] data;
        int          cnt;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  m_ptr  = 0;

    oflow_core_reg_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .start_set     (start_set),
        .num_active_pe (num_active_pe),
        .set_base_addr (set_base_addr),
        .req_i         (req_i),
        .data_i        (data_i),
        .wr_ready      (wr_ready),
`ifdef OFLOW_WB_ERR_CHECK_EN
        .err_o         (err_o),
`endif
        .grant_o       (grant_o),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .set_done      (set_done),
        .served_cnt    (served_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(grant_o), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_set_done"}, 64'(set_done), 64'd0);
        check({tag, "_served_cnt"}, 64'(served_cnt), 64'd0);
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr_en", 64'(wr_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", 64'(grant_o), 64'd1 << e.idx);
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    check("served_cnt", 64'(served_cnt), 64'(e.cnt));
                end
            end else if (grant_o !== '0) begin
                check("grant_without_wr", 64'(grant_o), 64'd0);
            end
        end
    end

    // Drives one set and models it: highest-priority eligible PE is the first at or after the pointer.
    task automatic run_set(input int n, input int base, input bit full_req, input bit bp,
                           input int ign_at, input int abort_after);
        int                ncl;
        int                got;
        int                cyc;
        int                idx;
        int                p;
        logic [PE_NUM-1:0] served, pend, hold, active, noise, req, elig;
        wr_t               e;
        ncl    = (n > PE_NUM) ? PE_NUM : n;
        got    = 0;
        cyc    = 0;
        served = '0;
        pend   = '0;
        hold   = '0;
        active = '0;
        for (int i = 0; i < ncl; i++) active[i] = 1'b1;

        @(negedge clk);
        start_set     = 1'b1;
        num_active_pe = CNT_W'(n);
        set_base_addr = ADDR_W'(base);
        @(negedge clk);
        start_set = 1'b0;

        while (got < ncl) begin
            if (abort_after >= 0 && got == abort_after) begin
                reset     = 1'b1;
                req_i     = '0;
                start_set = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                reset = 1'b0;
                m_ptr = 0;
                @(negedge clk);
                check("abort_no_set_done", 64'(set_done), 64'd0);
                check("abort_not_busy", 64'(busy), 64'd0);
                check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
                return;
            end
            if (cyc > 400) begin
                check("set_timeout_writes", 64'(got), 64'(ncl));
                break;
            end
            for (int i = 0; i < PE_NUM; i++) begin
                if (active[i] && !served[i] && !pend[i] && (full_req || $urandom_range(2) == 0))
                    pend[i] = 1'b1;
            end
            noise = full_req ? '1 : PE_NUM'($urandom);
            req   = pend | hold | (noise & (served | ~active));
            hold  = '0;
            req_i = req;
            for (int i = 0; i < PE_NUM; i++) data_i[i*DATA_W +: DATA_W] = $urandom;
            if (bp) wr_ready = !(cyc >= 6 && cyc < 9);
            else if (full_req) wr_ready = 1'b1;
            else wr_ready = ($urandom_range(3) != 0);
            if (cyc == ign_at) begin
                start_set     = 1'b1;
                num_active_pe = CNT_W'(3);
                set_base_addr = '0;
            end else begin
                start_set = 1'b0;
            end

            elig = req & ~served & active;
            if (wr_ready && elig != '0) begin
                idx = -1;
                for (int k = 0; k < PE_NUM; k++) begin
                    p = (m_ptr + k) % PE_NUM;
                    if (idx < 0 && elig[p]) idx = p;
                end
                served[idx] = 1'b1;
                pend[idx]   = 1'b0;
                hold[idx]   = 1'b1;
                got++;
                e.idx  = idx;
                e.addr = (base + idx) % (1 << ADDR_W);
                e.data = data_i[idx*DATA_W +: DATA_W];
                e.cnt  = got;
                exp_q.push_back(e);
                m_ptr = (idx + 1) % PE_NUM;
            end
            cyc++;
            @(negedge clk);
        end

        req_i     = '0;
        start_set = 1'b0;
        wr_ready  = 1'b1;
        check("no_done_with_last_write", 64'(set_done), 64'd0);
        check("busy_before_done", 64'(busy), 64'd1);
        @(negedge clk);
        check("set_done", 64'(set_done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd1);
        check("served_cnt_final", 64'(served_cnt), 64'(ncl));
        @(negedge clk);
        check("set_done_pulse", 64'(set_done), 64'd0);
        check("busy_cleared", 64'(busy), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start_set     = 1'b0;
        num_active_pe = '0;
        set_base_addr = '0;
        req_i         = '0;
        data_i        = '0;
        wr_ready      = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
`ifdef OFLOW_WB_ERR_CHECK_EN
        check("reset_err", 64'(err_o), 64'd0);
`endif
        reset = 1'b0;

        run_set(24, 'h100, 1'b1, 1'b0, -1, -1);   // full set from PE 0
        run_set(24, 'h040, 1'b1, 1'b0, -1, -1);   // wrap: starts again at PE 0
        run_set(5,  'h300, 1'b1, 1'b0, -1, -1);   // partial set, inactive requests ignored
        run_set(24, 'h010, 1'b1, 1'b1, -1, -1);   // three cycles of backpressure
        run_set(0,  'h055, 1'b0, 1'b0, -1, -1);   // zero set
        run_set(12, 'h080, 1'b1, 1'b0, 4,  -1);   // start_set mid-set ignored
`ifdef OFLOW_WB_ERR_CHECK_EN
        check("err_after_ignored_start", 64'(err_o), 64'd1);
`endif
        run_set(24, 'h100, 1'b1, 1'b0, -1, 7);    // reset after 7 writes
        run_set(24, 'h100, 1'b1, 1'b0, -1, -1);   // full set after reset
        run_set(30, 'h3F8, 1'b0, 1'b0, -1, -1);   // clamp and address wrap
        for (int s = 0; s < 8; s++)
            run_set($urandom_range(25), $urandom_range(1023), 1'b0, 1'b0, -1, -1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
